// File: rtl/barrel_pkg.sv
// barrel_pkg -- shared definitions for the pipelined left-rotate barrel shifter.
//
// Contents:
//   BRL_W / BRL_LG  default data width and the matching stage count / amount width
//   brl_payload_t   payload carried by one pipeline stage {data, amt[, mode]}
//   rotl_n()        golden left-rotate for a BRL_W-bit word
//   lsl_n()         golden logical shift left (zero fill) for a BRL_W-bit word
//
// Optional build macro: BARREL_SHIFT_MODE_EN adds the mode bit to the payload.
package barrel_pkg;

  localparam int BRL_W  = 8;
  localparam int BRL_LG = $clog2(BRL_W);

  typedef struct packed {
    logic [BRL_W-1:0]  data;
    logic [BRL_LG-1:0] amt;
`ifdef BARREL_SHIFT_MODE_EN
    logic              mode;
`endif
  } brl_payload_t;

  // Rotate left by n (taken modulo the width). A shift by the full width
  // yields zero, so n = 0 correctly returns the word unchanged.
  function automatic logic [BRL_W-1:0] rotl_n(input logic [BRL_W-1:0] data,
                                               input int unsigned     n);
    int unsigned s;
    s = n % BRL_W;
    return (data << s) | (data >> (BRL_W - s));
  endfunction

  // Logical shift left with zero fill (n modulo the width).
  function automatic logic [BRL_W-1:0] lsl_n(input logic [BRL_W-1:0] data,
                                              input int unsigned     n);
    return data << (n % BRL_W);
  endfunction

endpackage

// File: rtl/barrel_rotl_pipe_stage.sv
// rotl_stage -- one registered stage of the left-rotate barrel pipeline.
//
// Stage K conditionally rotates its predecessor's word left by 2^K when bit K
// of the carried amount is set, and registers {valid, data, amt[, mode]}.
// The load enable (ld) is the stage's slot in the ready chain computed by the
// top: when ld = 1 the stage captures its predecessor (including its valid),
// otherwise it holds.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset (clears all state)
//   ld                capture predecessor this cycle
//   prev_valid/data/amt[/mode]  predecessor stage (or the input port for K = 0)
//   valid/data/amt[/mode]       registered outputs of this stage
//
// Optional build macro: BARREL_SHIFT_MODE_EN (mode = 1 zero-fills instead of
// wrapping the bits shifted out).
module rotl_stage #(
  parameter int W  = 8,
  parameter int LG = $clog2(W),
  parameter int K  = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld,
  input  logic          prev_valid,
  input  logic [W-1:0]  prev_data,
  input  logic [LG-1:0] prev_amt,
`ifdef BARREL_SHIFT_MODE_EN
  input  logic          prev_mode,
  output logic          mode,
`endif
  output logic          valid,
  output logic [W-1:0]  data,
  output logic [LG-1:0] amt
);

  localparam int S = 1 << K;

  logic          valid_q, valid_d;
  logic [W-1:0]  data_q, data_d;
  logic [LG-1:0] amt_q, amt_d;
  logic [W-1:0]  moved, wrapped;
`ifdef BARREL_SHIFT_MODE_EN
  logic          mode_q, mode_d;
`endif

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    amt_d   = amt_q;
`ifdef BARREL_SHIFT_MODE_EN
    mode_d  = mode_q;
`endif
    // Split the rotate into the shifted part and the wrapped-around top bits
    // so shift mode only has to drop the wrapped part.
    moved   = prev_data << S;
    wrapped = prev_data >> (W - S);
`ifdef BARREL_SHIFT_MODE_EN
    if (prev_mode) begin
      wrapped = '0;
    end
`endif
    if (ld) begin
      valid_d = prev_valid;
      amt_d   = prev_amt;
      data_d  = prev_amt[K] ? (moved | wrapped) : prev_data;
`ifdef BARREL_SHIFT_MODE_EN
      mode_d  = prev_mode;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
`ifdef BARREL_SHIFT_MODE_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
`ifdef BARREL_SHIFT_MODE_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign amt   = amt_q;
`ifdef BARREL_SHIFT_MODE_EN
  assign mode  = mode_q;
`endif

endmodule

// File: rtl/barrel_rotl_pipe.sv
// barrel_rotl_pipe -- pipelined left-rotate barrel shifter with valid/ready
// handshakes on both sides.
//
// LG = log2(W) registered stages; stage k rotates by 2^k when amt bit k is
// set. Latency is LG cycles, throughput one word per cycle, and any empty
// stage accepts data even when the output is stalled (bubbles collapse).
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset; empties the pipeline
//   in_valid   producer has a word          in_ready   word accepted this cycle
//   in_data    word to rotate               in_amt     left-rotate amount
//   in_mode    (BARREL_SHIFT_MODE_EN only) 1 = logical shift left, 0 = rotate
//   out_valid  out_data is valid            out_ready  consumer accepts
//   out_data   rotated word
//
// Optional build macro: BARREL_SHIFT_MODE_EN adds in_mode; without it the
// block always rotates. Latency and handshake are the same in both builds.
module barrel_rotl_pipe
  import barrel_pkg::*;
#(
  parameter  int W  = BRL_W,
  localparam int LG = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [LG-1:0] in_amt,
`ifdef BARREL_SHIFT_MODE_EN
  input  logic          in_mode,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data
);

  // Index 0 is the input port, index k+1 is the output of stage k.
  logic          sv [LG+1];
  logic [W-1:0]  sd [LG+1];
  logic [LG-1:0] sa [LG+1];
`ifdef BARREL_SHIFT_MODE_EN
  logic          sm [LG+1];
`endif

  logic [LG-1:0] v_vec;  // per-stage valid, for the ready chain
  logic [LG-1:0] rdy;    // rdy[k]: stage k loads this cycle

  assign sv[0] = in_valid;
  assign sd[0] = in_data;
  assign sa[0] = in_amt;
`ifdef BARREL_SHIFT_MODE_EN
  assign sm[0] = in_mode;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < LG; gi++) begin : g_stage
      rotl_stage #(
        .W (W),
        .LG(LG),
        .K (gi)
      ) u_stage (
        .clk       (clk),
        .reset     (reset),
        .ld        (rdy[gi]),
        .prev_valid(sv[gi]),
        .prev_data (sd[gi]),
        .prev_amt  (sa[gi]),
`ifdef BARREL_SHIFT_MODE_EN
        .prev_mode (sm[gi]),
        .mode      (sm[gi+1]),
`endif
        .valid     (sv[gi+1]),
        .data      (sd[gi+1]),
        .amt       (sa[gi+1])
      );
      assign v_vec[gi] = sv[gi+1];
    end
  endgenerate

  // Ready ripples back from the consumer: a stage can load if it is empty or
  // if the stage after it is moving on this same edge.
  always_comb begin
    logic r;
    rdy = '0;
    r   = out_ready;
    for (int k = LG - 1; k >= 0; k--) begin
      r      = ~v_vec[k] | r;
      rdy[k] = r;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = sv[LG];
  assign out_data  = sd[LG];

  // The amount (and mode) leaving the last stage has no further consumer.
`ifdef BARREL_SHIFT_MODE_EN
  wire unused_tail = ^{sa[LG], sm[LG]};
`else
  wire unused_tail = ^sa[LG];
`endif

endmodule

// File: tb/tb_barrel_rotl_pipe.sv
// Testbench for barrel_rotl_pipe (W = 8): directed steps plus a randomized
// handshake run scored against the package golden model.
// Optional build macro: BARREL_SHIFT_MODE_EN enables the shift-mode steps.
module tb_barrel_rotl_pipe;
  import barrel_pkg::*;

  localparam int W  = BRL_W;
  localparam int LG = BRL_LG;
  localparam int NW = 10000;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [LG-1:0] in_amt;
  logic          in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;

  always #5 clk = ~clk;

  barrel_rotl_pipe #(.W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
`ifdef BARREL_SHIFT_MODE_EN
    .in_mode  (in_mode),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge, then settle 1 time unit so the
  // handshake flags seen afterwards describe the coming rising edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic [LG-1:0] a,
                      input logic m, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_amt    = a;
    in_mode   = m;
    out_ready = ordy;
    #1;
  endtask

  logic [W-1:0] sweep_exp [8] = '{8'hA5, 8'h4B, 8'h96, 8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2};
  logic [W-1:0] hold_exp  [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
  logic [W-1:0] exp_q [$];

  initial begin
    int idx, n, cyc, got, sent;
    logic pending;
    logic [W-1:0] r_data;
    logic [LG-1:0] r_amt;
    logic r_mode;

    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = 1'b0;
    out_ready = 1'b0;
    #2 reset = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    // Single word: latency of 3 cycles
    step(1'b1, 8'b1000_0001, 3'd1, 1'b0, 1'b1);
    chk("t1_in_ready", in_ready, 1);
    for (int c = 1; c <= 3; c++) begin
      step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      chk("t1_latency_valid", out_valid, (c == 3) ? 1 : 0);
    end
    chk("t1_data", out_data, 8'b0000_0011);
    $display("t1 out %h", out_data);
    step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    chk("t1_consumed", out_valid, 0);

    // Sweep amt 0..7 on A5, back to back
    idx = 0; n = 0;
    for (int c = 0; c < 12; c++) begin
      if (idx < 8) step(1'b1, 8'hA5, idx[LG-1:0], 1'b0, 1'b1);
      else         step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready && n < 8) begin
        chk("t2_data", out_data, sweep_exp[n]);
        chk("t2_cycle", c, n + 3);
        $display("t2 out[%0d] %h", n, out_data);
        n++;
      end
    end
    chk("t2_accepted", idx, 8);
    chk("t2_results", n, 8);

    // Backpressure: 3 accepted, output held stable
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      step(idx < 4, 8'h01, idx[LG-1:0], 1'b0, 1'b0);
      if (in_valid && in_ready) idx++;
      if (c >= 3) begin
        chk("t3_stall_valid", out_valid, 1);
        chk("t3_stall_data", out_data, 8'h01);
        chk("t3_stall_in_ready", in_ready, 0);
      end
    end
    chk("t3_accepted_stalled", idx, 3);
    n = 0;
    for (int c = 0; c < 8; c++) begin
      step(idx < 4, 8'h01, idx[LG-1:0], 1'b0, 1'b1);
      if (c == 0) chk("t3_accept_4th", in_ready, 1);
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready && n < 4) begin
        chk("t3_drain_data", out_data, hold_exp[n]);
        $display("t3 out[%0d] %h", n, out_data);
        n++;
      end
    end
    chk("t3_accepted", idx, 4);
    chk("t3_drained", n, 4);

    // Asynchronous reset with 2 words in flight
    step(1'b1, 8'h11, 3'd0, 1'b0, 1'b0);
    step(1'b1, 8'h11, 3'd1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    chk("t4_pre_valid", out_valid, 1);
    chk("t4_pre_data", out_data, 8'h11);
    #2 reset = 1'b1;
    #1;
    chk("t4_rst_valid", out_valid, 0);
    chk("t4_rst_data", out_data, 0);
    chk("t4_rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      chk("t4_no_stale", out_valid, 0);
    end

`ifdef BARREL_SHIFT_MODE_EN
    // Shift mode versus rotate mode
    step(1'b1, 8'hFF, 3'd3, 1'b1, 1'b1);
    step(1'b1, 8'hFF, 3'd3, 1'b0, 1'b1);
    step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    chk("t6_shift_valid", out_valid, 1);
    chk("t6_shift_data", out_data, 8'hF8);
    step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    chk("t6_rot_valid", out_valid, 1);
    chk("t6_rot_data", out_data, 8'hFF);
    step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
`endif

    // Random valid/ready toggling against the golden model
    pending = 1'b0; cyc = 0; got = 0; sent = 0;
    r_data = '0; r_amt = '0; r_mode = 1'b0;
    while (got < NW && cyc < 60000) begin
      if (!pending && sent < NW && $urandom_range(3) != 0) begin
        pending = 1'b1;
        r_data  = W'($urandom);
        r_amt   = LG'($urandom);
`ifdef BARREL_SHIFT_MODE_EN
        r_mode  = 1'($urandom);
`else
        r_mode  = 1'b0;
`endif
      end
      step(pending, r_data, r_amt, r_mode, $urandom_range(3) != 0);
      if (in_valid && in_ready) begin
        exp_q.push_back(r_mode ? lsl_n(r_data, r_amt) : rotl_n(r_data, r_amt));
        pending = 1'b0;
        sent++;
      end
      if (out_valid && out_ready) begin
        chk("rnd_expected_word", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("rnd_data", out_data, exp_q.pop_front());
        got++;
      end
      cyc++;
    end
    chk("rnd_received", got, NW);
    chk("rnd_leftover", exp_q.size(), 0);
    $display("random run: %0d words in %0d cycles", got, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
